// File: rtl/adc_rr_arbiter.sv
// adc_rr_arbiter
// Shares one 32-bit AXI-Stream sample port between eight ADC receiver
// channels. Grants one requesting channel at a time in round-robin order,
// latches its sample, pulses ack to that channel and emits the sample tagged
// with the channel ID. Frames of FRAME_LEN samples are delimited by m_tlast.
// A channel that waits MAX_WAIT cycles unserved sets its sticky overrun bit.
//
// Ports
//   clk        sample clock
//   rst        asynchronous active-high reset
//   start      capture enable (level)
//   ch_en      per-channel enable mask
//   req        per-channel request, data_flat slice stable while high
//   data_flat  channel i sample on bits [32i+31:32i]
//   ack        one-cycle grant pulse back to the granted channel
//   m_tdata    granted sample
//   m_tuser    channel ID of m_tdata
//   m_tvalid   AXIS valid
//   m_tready   AXIS ready
//   m_tlast    last sample of a frame
//   overrun    sticky per-channel wait-timeout flags
//   busy       registered (state != IDLE)
//
// state | meaning
// IDLE  | capture disabled, outputs quiescent
// ARB   | pick next eligible channel after the round-robin pointer
// OUT   | beat presented on the stream port, waiting for m_tready
module adc_rr_arbiter #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned MAX_WAIT  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   ch_en,
  input  logic [7:0]   req,
  input  logic [255:0] data_flat,
  output logic [7:0]   ack,
  output logic [31:0]  m_tdata,
  output logic [2:0]   m_tuser,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic [7:0]   overrun,
  output logic         busy
);

  localparam int unsigned     WW       = $clog2(MAX_WAIT + 1);
  localparam logic [15:0]     LAST_CNT = 16'(FRAME_LEN - 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ARB, OUT} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr;
  logic [7:0]    served;
  logic [15:0]   count;
  logic [WW-1:0] wait_cnt [8];
  logic [7:0]    eligible;
  logic [7:0]    grant;
  logic [2:0]    grant_idx;
  logic [2:0]    scan_idx;
  logic          grant_any;
  logic          accept;

  // served masks a channel after its grant until its request drops, so one
  // request assertion yields exactly one sample.
  assign eligible = req & ch_en & ~served;
  assign accept   = (state == OUT) && m_tready;

  always_comb begin
    state_n   = state;
    grant     = '0;
    grant_idx = ptr;
    grant_any = 1'b0;
    scan_idx  = ptr;
    case (state)
      IDLE: begin
        if (start) state_n = ARB;
      end
      ARB: begin
        if (!start) begin
          state_n = IDLE;
        end else begin
          // scan ptr+1 .. ptr+8 (mod 8); the last slot is ptr itself
          for (int k = 1; k <= 8; k++) begin
            scan_idx = ptr + 3'(k);
            if (!grant_any && eligible[scan_idx]) begin
              grant_any = 1'b1;
              grant_idx = scan_idx;
            end
          end
          if (grant_any) begin
            grant[grant_idx] = 1'b1;
            state_n          = OUT;
          end
        end
      end
      OUT: begin
        if (m_tready) state_n = ARB;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 3'd7;
      served   <= '0;
      count    <= '0;
      ack      <= '0;
      m_tdata  <= '0;
      m_tuser  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy   <= (state_n != IDLE);
      ack    <= grant;
      served <= req & (served | grant);

      if ((state == IDLE && start) || (state == ARB && !start))
        count <= '0;
      else if (accept)
        count <= (count == LAST_CNT) ? '0 : count + 16'd1;

      if (grant_any) begin
        m_tdata  <= data_flat[{grant_idx, 5'd0} +: 32];
        m_tuser  <= grant_idx;
        m_tvalid <= 1'b1;
        m_tlast  <= (count == LAST_CNT);
        ptr      <= grant_idx;
      end else if (accept) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) wait_cnt[i] <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (state == IDLE || !eligible[i] || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != WAIT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + WW'(1);
          if (wait_cnt[i] == WAIT_MAX - WW'(1)) overrun[i] <= 1'b1;
        end
      end
      // a fresh capture session starts with clean overrun flags
      if (state == IDLE && start) overrun <= '0;
    end
  end

endmodule

// File: tb/tb_adc_rr_arbiter.sv
module tb_adc_rr_arbiter;

  localparam int FRAME_LEN = 4;
  localparam int MAX_WAIT  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   ch_en = '0;
  logic [7:0]   req = '0;
  logic [255:0] data_flat = '0;
  logic [7:0]   ack;
  logic [31:0]  m_tdata;
  logic [2:0]   m_tuser;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic [7:0]   overrun;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  adc_rr_arbiter #(.FRAME_LEN(FRAME_LEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .req(req),
    .data_flat(data_flat), .ack(ack), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: session active flag, pending-beat flag, pointer of
  // last served channel, per-channel served/wait/overrun bookkeeping.
  bit          mb_active, mb_out;
  int          mb_ptr, mb_cnt;
  bit [7:0]    mb_served, mb_ovr;
  int          mb_wait [8];
  logic [7:0]  e_ack;
  logic [31:0] e_data;
  logic [2:0]  e_user;
  logic        e_valid, e_last, e_busy;

  function automatic void model_reset();
    mb_active = 0; mb_out = 0; mb_ptr = 7; mb_cnt = 0;
    mb_served = '0; mb_ovr = '0;
    for (int i = 0; i < 8; i++) mb_wait[i] = 0;
    e_ack = '0; e_data = '0; e_user = '0; e_valid = 0; e_last = 0; e_busy = 0;
  endfunction

  function automatic void model_step();
    bit [7:0] elig;
    int g;
    bit was_active;
    elig = req & ch_en & ~mb_served;
    g = -1;
    was_active = mb_active;
    e_ack = '0;
    if (!mb_active) begin
      if (start) begin mb_active = 1; mb_ovr = '0; mb_cnt = 0; end
    end else if (!mb_out) begin
      if (!start) begin
        mb_active = 0; mb_cnt = 0;
      end else begin
        for (int k = 1; k <= 8; k++)
          if (g < 0 && elig[(mb_ptr + k) % 8]) g = (mb_ptr + k) % 8;
      end
    end else if (m_tready) begin
      e_valid = 0; e_last = 0; mb_out = 0;
      mb_cnt = (mb_cnt + 1) % FRAME_LEN;
    end
    for (int i = 0; i < 8; i++) begin
      if (!was_active || !elig[i] || g == i) mb_wait[i] = 0;
      else if (mb_wait[i] < MAX_WAIT) begin
        mb_wait[i]++;
        if (mb_wait[i] == MAX_WAIT) mb_ovr[i] = 1;
      end
    end
    for (int i = 0; i < 8; i++) mb_served[i] = req[i] && (mb_served[i] || g == i);
    if (g >= 0) begin
      e_ack[g] = 1'b1;
      e_data   = data_flat[32*g +: 32];
      e_user   = 3'(g);
      e_valid  = 1;
      e_last   = (mb_cnt == FRAME_LEN - 1);
      mb_ptr   = g;
      mb_out   = 1;
    end
    e_busy = mb_active;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("ack", ack, e_ack);
    chk("tvalid", m_tvalid, e_valid);
    chk("tdata", m_tdata, e_data);
    chk("tuser", m_tuser, e_user);
    chk("tlast", m_tlast, e_last);
    chk("overrun", overrun, mb_ovr);
    chk("busy", busy, e_busy);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d0;
    logic [7:0]  drop;
    int          n, beats, lowest;

    for (int i = 0; i < 8; i++) data_flat[32*i +: 32] = $urandom;
    do_reset();

    // single channel
    data_flat[31:0] = 32'hDEADBEEF;
    start = 1; ch_en = 8'hFF; req = 8'h01; m_tready = 1;
    n = 0;
    repeat (8) begin
      tick();
      if (ack[0]) begin n++; chk("single_data", m_tdata, 32'hDEADBEEF); end
    end
    chk("single_once", n, 1);
    req = 8'h00; tick();
    req = 8'h01;
    repeat (4) begin tick(); if (ack[0]) n++; end
    chk("single_again", n, 2);

    // round robin
    do_reset();
    for (int i = 0; i < 8; i++) data_flat[32*i +: 32] = $urandom;
    start = 1; ch_en = 8'hFF; m_tready = 1;
    drop = '0; n = 0;
    for (int c = 0; c < 80 && n < 9; c++) begin
      req = ~drop;
      tick();
      drop = e_ack;
      if (ack != 0) begin
        chk("rr_user", m_tuser, n % 8);
        n++;
      end
    end
    chk("rr_count", n, 9);

    // backpressure
    do_reset();
    d0 = $urandom;
    data_flat[31:0] = d0;
    start = 1; ch_en = 8'hFF; req = 8'h01; m_tready = 0;
    for (int c = 0; c < 10 && !e_valid; c++) tick();
    chk("bp_first", m_tvalid, 1);
    req = 8'h0F;
    repeat (10) begin
      tick();
      chk("bp_hold_data", m_tdata, d0);
      chk("bp_hold_user", m_tuser, 0);
      chk("bp_hold_valid", m_tvalid, 1);
      chk("bp_no_ack", ack, 0);
    end
    chk("bp_overrun", overrun, 8'h0E);
    m_tready = 1;
    repeat (4) tick();

    // framing with random requests and ready
    do_reset();
    start = 1; ch_en = 8'hFF;
    beats = 0;
    for (int c = 0; c < 300 && beats < 9; c++) begin
      req = 8'($urandom);
      m_tready = 1'($urandom);
      if (m_tvalid && m_tready) begin
        beats++;
        chk("frame_last", m_tlast, (beats % 4 == 0));
      end
      tick();
    end
    chk("frame_beats", beats, 9);

    // mask and stop
    do_reset();
    start = 1; ch_en = 8'hFE; req = 8'h03; m_tready = 1;
    n = 0;
    repeat (8) begin
      tick();
      chk("mask_ack0", ack[0], 0);
      if (ack[1]) n++;
    end
    chk("mask_ch1_once", n, 1);
    req = 8'h01; tick();
    req = 8'h03; m_tready = 0;
    for (int c = 0; c < 6 && !e_valid; c++) tick();
    chk("stop_pending", m_tvalid, 1);
    start = 0;
    repeat (3) begin tick(); chk("stop_hold", m_tvalid, 1); end
    m_tready = 1;
    tick();
    chk("stop_accept_busy", busy, 1);
    chk("stop_accept_valid", m_tvalid, 0);
    tick();
    chk("stop_idle_busy", busy, 0);

    // async reset while a beat is pending
    do_reset();
    start = 1; ch_en = 8'hFF; req = 8'h3C; m_tready = 0;
    repeat (8) tick();
    chk("pre_rst_overrun", overrun, 8'h38);
    chk("pre_rst_valid", m_tvalid, 1);
    do_reset();
    ch_en = 8'($urandom);
    req = 8'($urandom);
    while ((ch_en & req) == 0) begin ch_en = 8'($urandom); req = 8'($urandom); end
    lowest = -1;
    for (int i = 7; i >= 0; i--) if (ch_en[i] && req[i]) lowest = i;
    m_tready = 1; start = 1;
    n = 0;
    for (int c = 0; c < 6 && n == 0; c++) begin
      tick();
      if (ack != 0) begin n = 1; chk("rst_first_grant", m_tuser, lowest); end
    end
    chk("rst_grant_seen", n, 1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      start    = ($urandom % 16) != 0;
      ch_en    = ($urandom % 4 == 0) ? 8'($urandom) : ch_en | 8'($urandom);
      req      = 8'($urandom);
      m_tready = ($urandom % 4) != 0;
      for (int i = 0; i < 8; i++) if (!req[i]) data_flat[32*i +: 32] = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
